// File: rtl/pipeline_calc_scheduler.sv
// pipeline_calc_scheduler
//   Two requesters share one pipeline_calculate datapath (operands A..E, result S).
//   Round-robin arbitration with valid/ready on the operand side. The granted operand
//   set is registered onto pipe_A..pipe_E, and a tag records which requester owns that
//   issue slot. Each returning pipe_S goes to the owner as a one-cycle rsp pulse. A
//   drain FSM (RUN/DRAIN/DONE) stops intake on request and reports when the pipe is empty.
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   inN_valid/inN_ops/inN_ready   operand handshake, ops = {E,D,C,B,A}
//   pipe_A..pipe_E / pipe_S       datapath operands out / result in
//   rspN_valid/rspN_data          per-requester result pulse and held data
//   drain_req/drained             drain request level / high in DONE
//   inflight                      issued results not yet returned

// Per-requester response register. Data is updated only when this requester
// owns the returning slot, so the other lane keeps its last result.
module pipeline_calc_scheduler_rsp #(
  parameter int W  = 5,
  parameter bit ID = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tail_vld,
  input  logic         tail_tag,
  input  logic [W-1:0] pipe_s,
  output logic         rsp_valid,
  output logic [W-1:0] rsp_data
);
  logic hit;
  assign hit = tail_vld & (tail_tag == ID);

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= hit;
      if (hit) rsp_data <= pipe_s;
    end
  end
endmodule

module pipeline_calc_scheduler #(
  parameter int W       = 5,
  parameter int LATENCY = 2,
  localparam int IW     = $clog2(LATENCY + 2)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in0_valid,
  input  logic [5*W-1:0] in0_ops,
  output logic           in0_ready,
  input  logic           in1_valid,
  input  logic [5*W-1:0] in1_ops,
  output logic           in1_ready,
  output logic [W-1:0]   pipe_A,
  output logic [W-1:0]   pipe_B,
  output logic [W-1:0]   pipe_C,
  output logic [W-1:0]   pipe_D,
  output logic [W-1:0]   pipe_E,
  input  logic [W-1:0]   pipe_S,
  output logic           rsp0_valid,
  output logic [W-1:0]   rsp0_data,
  output logic           rsp1_valid,
  output logic [W-1:0]   rsp1_data,
  input  logic           drain_req,
  output logic           drained,
  output logic [IW-1:0]  inflight
);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic rr;            // requester favoured when both are valid
  logic grant0, grant1, open, acc0, acc1, acc, ret;

  // Stage 0 sits alongside the pipe_* register; stages 1..LATENCY follow the
  // datapath, so stage LATENCY lines up with pipe_S.
  logic [LATENCY:0] vld_pipe, tag_pipe;

  assign grant0    = in0_valid & (~in1_valid | ~rr);
  assign grant1    = in1_valid & (~in0_valid |  rr);
  assign open      = (state == RUN) & ~drain_req;
  assign in0_ready = open & grant0;
  assign in1_ready = open & grant1;
  assign acc0      = in0_valid & in0_ready;
  assign acc1      = in1_valid & in1_ready;
  assign acc       = acc0 | acc1;
  assign ret       = vld_pipe[LATENCY];
  assign drained   = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      {pipe_E, pipe_D, pipe_C, pipe_B, pipe_A} <= '0;
      vld_pipe <= '0;
      tag_pipe <= '0;
      rr       <= 1'b0;
      inflight <= '0;
      state    <= RUN;
    end else begin
      if (acc0)      {pipe_E, pipe_D, pipe_C, pipe_B, pipe_A} <= in0_ops;
      else if (acc1) {pipe_E, pipe_D, pipe_C, pipe_B, pipe_A} <= in1_ops;
      else           {pipe_E, pipe_D, pipe_C, pipe_B, pipe_A} <= '0;
      vld_pipe <= {vld_pipe[LATENCY-1:0], acc};
      tag_pipe <= {tag_pipe[LATENCY-1:0], acc1};
      if (acc0)      rr <= 1'b1;
      else if (acc1) rr <= 1'b0;
      // A result leaves the count on the edge that raises its rsp pulse.
      if (acc & ~ret)      inflight <= inflight + IW'(1);
      else if (~acc & ret) inflight <= inflight - IW'(1);
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (drain_req)       state_nx = DRAIN;
      DRAIN:   if (inflight == '0)  state_nx = DONE;
      DONE:    if (!drain_req)      state_nx = RUN;
      default:                      state_nx = RUN;
    endcase
  end

  logic [1:0]        rsp_v;
  logic [1:0][W-1:0] rsp_d;

  for (genvar g = 0; g < 2; g++) begin : g_rsp
    pipeline_calc_scheduler_rsp #(.W(W), .ID(g == 1)) u_rsp (
      .clk       (clk),
      .reset     (reset),
      .tail_vld  (vld_pipe[LATENCY]),
      .tail_tag  (tag_pipe[LATENCY]),
      .pipe_s    (pipe_S),
      .rsp_valid (rsp_v[g]),
      .rsp_data  (rsp_d[g])
    );
  end

  assign rsp0_valid = rsp_v[0];
  assign rsp1_valid = rsp_v[1];
  assign rsp0_data  = rsp_d[0];
  assign rsp1_data  = rsp_d[1];
endmodule

// File: tb/tb_pipeline_calc_scheduler.sv
module tb_pipeline_calc_scheduler;
  localparam int W = 5;
  localparam int L = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         in0_valid, in1_valid, in0_ready, in1_ready;
  logic [5*W-1:0] in0_ops, in1_ops;
  logic [W-1:0] pipe_A, pipe_B, pipe_C, pipe_D, pipe_E, pipe_S;
  logic         rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp0_data, rsp1_data;
  logic         drain_req, drained;
  logic [1:0]   inflight;

  always #5 clk = ~clk;

  pipeline_calc_scheduler #(.W(W), .LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .in0_valid(in0_valid), .in0_ops(in0_ops), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_ops(in1_ops), .in1_ready(in1_ready),
    .pipe_A(pipe_A), .pipe_B(pipe_B), .pipe_C(pipe_C), .pipe_D(pipe_D), .pipe_E(pipe_E),
    .pipe_S(pipe_S),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .drain_req(drain_req), .drained(drained), .inflight(inflight)
  );

  // Stub datapath: sum of operands, delayed L cycles.
  logic [W-1:0] sd [L];
  always_ff @(posedge clk) begin
    sd[0] <= pipe_A + pipe_B + pipe_C + pipe_D + pipe_E;
    for (int i = 1; i < L; i++) sd[i] <= sd[i-1];
  end
  assign pipe_S = sd[L-1];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [24:0] pk(input int a, b, c, d, e);
    pk = {5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic logic [4:0] sum5(input logic [24:0] o);
    int s;
    s = int'(o[4:0]) + int'(o[9:5]) + int'(o[14:10]) + int'(o[19:15]) + int'(o[24:20]);
    return 5'(s % 32);
  endfunction

  // ---------------- reference model: queue of pending results ----------------
  typedef struct { int tag; logic [4:0] data; int left; } pend_t;
  pend_t q[$];
  int    rr_m, mode_m;          // mode: 0 accepting, 1 draining, 2 drained
  logic  m_q0v, m_q1v;
  logic [4:0]  m_q0d, m_q1d;
  logic [24:0] m_pipe;
  logic  exp_r0, exp_r1;
  int    cnt0, cnt1, peak;

  task automatic model_step();
    int n_old;
    pend_t p;
    if (reset) begin
      q.delete(); rr_m = 0; mode_m = 0;
      m_q0v = 0; m_q1v = 0; m_q0d = 0; m_q1d = 0; m_pipe = 0;
      return;
    end
    n_old = q.size();
    m_q0v = 0; m_q1v = 0;
    foreach (q[i]) q[i].left--;
    if (q.size() > 0 && q[0].left == 0) begin
      p = q.pop_front();
      if (p.tag == 0) begin m_q0v = 1; m_q0d = p.data; end
      else            begin m_q1v = 1; m_q1d = p.data; end
    end
    if (exp_r0) q.push_back(pend_t'{0, sum5(in0_ops), L + 1});
    if (exp_r1) q.push_back(pend_t'{1, sum5(in1_ops), L + 1});
    m_pipe = exp_r0 ? in0_ops : (exp_r1 ? in1_ops : 25'd0);
    if (exp_r0)      rr_m = 1;
    else if (exp_r1) rr_m = 0;
    case (mode_m)
      0: if (drain_req)  mode_m = 1;
      1: if (n_old == 0) mode_m = 2;
      default: if (!drain_req) mode_m = 0;
    endcase
  endtask

  // One cycle: inputs already driven; check against model, advance one edge.
  task automatic tick();
    bit g0, g1;
    #1;
    g0 = in0_valid && (!in1_valid || rr_m == 0);
    g1 = in1_valid && (!in0_valid || rr_m == 1);
    exp_r0 = (mode_m == 0) && !drain_req && g0;
    exp_r1 = (mode_m == 0) && !drain_req && g1;
    chk("in0_ready", in0_ready, exp_r0);
    chk("in1_ready", in1_ready, exp_r1);
    chk("rsp0_valid", rsp0_valid, m_q0v);
    chk("rsp1_valid", rsp1_valid, m_q1v);
    chk("rsp0_data", rsp0_data, m_q0d);
    chk("rsp1_data", rsp1_data, m_q1d);
    chk("inflight", inflight, q.size());
    chk("drained", drained, mode_m == 2);
    chk("pipe_ops", {pipe_E, pipe_D, pipe_C, pipe_B, pipe_A}, m_pipe);
    if (rsp0_valid) cnt0++;
    if (rsp1_valid) cnt1++;
    if (int'(inflight) > peak) peak = int'(inflight);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit r, dr, v0, input logic [24:0] o0, input bit v1, input logic [24:0] o1);
    reset = r; drain_req = dr; in0_valid = v0; in0_ops = o0; in1_valid = v1; in1_ops = o1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit rst, drn_in, v0; logic [24:0] o0; bit v1; logic [24:0] o1;
    bit r0, r1, q0v; int q0d; bit q1v; int q1d; int inf; bit drn;
  } vec_t;
  vec_t vt [16];

  function automatic vec_t row(input bit rst, dri, v0, input logic [24:0] o0, input bit v1,
                               input logic [24:0] o1, input bit r0, r1, q0v, input int q0d,
                               input bit q1v, input int q1d, input int inf, input bit drn);
    vec_t t;
    t.rst = rst; t.drn_in = dri; t.v0 = v0; t.o0 = o0; t.v1 = v1; t.o1 = o1;
    t.r0 = r0; t.r1 = r1; t.q0v = q0v; t.q0d = q0d; t.q1v = q1v; t.q1d = q1d;
    t.inf = inf; t.drn = drn;
    return t;
  endfunction

  initial begin
    logic [24:0] o1, oa, ob, o3, o5;
    o1 = pk(6, 7, 8, 3, 10);
    oa = pk(4, 8, 7, 3, 1);
    ob = pk(1, 9, 6, 3, 5);
    o3 = pk(8, 7, 3, 7, 2);
    o5 = pk(6, 10, 3, 3, 10);
    //           rst dr v0 o0 v1 o1   r0 r1 q0v q0d q1v q1d inf drn
    vt[0]  = row(0, 0, 1, o1, 0, 0,   1, 0, 0, 0,  0, 0,  0, 0);
    vt[1]  = row(0, 0, 0, 0,  0, 0,   0, 0, 0, 0,  0, 0,  1, 0);
    vt[2]  = row(0, 0, 0, 0,  0, 0,   0, 0, 0, 0,  0, 0,  1, 0);
    vt[3]  = row(0, 0, 0, 0,  0, 0,   0, 0, 0, 0,  0, 0,  1, 0);
    vt[4]  = row(0, 0, 0, 0,  0, 0,   0, 0, 1, 2,  0, 0,  0, 0);
    vt[5]  = row(0, 0, 0, 0,  0, 0,   0, 0, 0, 2,  0, 0,  0, 0);
    vt[6]  = row(1, 0, 0, 0,  0, 0,   0, 0, 0, 2,  0, 0,  0, 0);
    vt[7]  = row(0, 0, 1, oa, 1, ob,  1, 0, 0, 0,  0, 0,  0, 0);
    vt[8]  = row(0, 0, 1, oa, 1, ob,  0, 1, 0, 0,  0, 0,  1, 0);
    vt[9]  = row(0, 0, 1, oa, 1, ob,  1, 0, 0, 0,  0, 0,  2, 0);
    vt[10] = row(0, 0, 1, oa, 1, ob,  0, 1, 0, 0,  0, 0,  3, 0);
    vt[11] = row(0, 0, 0, 0,  0, 0,   0, 0, 1, 23, 0, 0,  3, 0);
    vt[12] = row(0, 0, 0, 0,  0, 0,   0, 0, 0, 23, 1, 24, 2, 0);
    vt[13] = row(0, 0, 0, 0,  0, 0,   0, 0, 1, 23, 0, 24, 1, 0);
    vt[14] = row(0, 0, 0, 0,  0, 0,   0, 0, 0, 23, 1, 24, 0, 0);
    vt[15] = row(0, 0, 0, 0,  0, 0,   0, 0, 0, 23, 0, 24, 0, 0);

    // power-on reset
    drv(1, 0, 0, 0, 0, 0);
    exp_r0 = 0; exp_r1 = 0; cnt0 = 0; cnt1 = 0; peak = 0;
    repeat (2) @(posedge clk);
    #1;
    model_step();
    chk("reset_inflight", inflight, 0);
    chk("reset_drained", drained, 0);
    chk("reset_pipe", {pipe_E, pipe_D, pipe_C, pipe_B, pipe_A}, 0);
    chk("reset_rsp", {rsp1_valid, rsp0_valid, rsp1_data, rsp0_data}, 0);

    for (int i = 0; i < 16; i++) begin
      drv(vt[i].rst, vt[i].drn_in, vt[i].v0, vt[i].o0, vt[i].v1, vt[i].o1);
      #1;
      chk($sformatf("t%0d_ready0", i), in0_ready, vt[i].r0);
      chk($sformatf("t%0d_ready1", i), in1_ready, vt[i].r1);
      chk($sformatf("t%0d_rsp0", i), {rsp0_valid, rsp0_data}, {vt[i].q0v, 5'(vt[i].q0d)});
      chk($sformatf("t%0d_rsp1", i), {rsp1_valid, rsp1_data}, {vt[i].q1v, 5'(vt[i].q1d)});
      chk($sformatf("t%0d_inflight", i), inflight, vt[i].inf);
      chk($sformatf("t%0d_drained", i), drained, vt[i].drn);
      tick();
    end

    // in1 alone for 3 cycles: 3 pulses of 27, inflight peaks at 3
    cnt0 = 0; cnt1 = 0; peak = 0;
    for (int i = 0; i < 3; i++) begin drv(0, 0, 0, 0, 1, o3); tick(); end
    for (int i = 0; i < 5; i++) begin drv(0, 0, 0, 0, 0, 0); tick(); end
    chk("s3_rsp1_count", cnt1, 3);
    chk("s3_rsp0_count", cnt0, 0);
    chk("s3_peak", peak, 3);
    chk("s3_data", rsp1_data, 27);

    // drain with 2 in flight; in0 keeps the same ops valid until re-accepted
    cnt0 = 0;
    for (int i = 0; i < 2; i++) begin drv(0, 0, 1, o1, 0, 0); tick(); end
    drv(0, 1, 1, o1, 0, 0);
    #1 chk("s4_ready_drop", in0_ready, 0);
    tick();
    for (int i = 0; i < 3; i++) tick();
    chk("s4_drained", drained, 1);
    chk("s4_resp_count", cnt0, 2);
    drv(0, 0, 1, o1, 0, 0);
    #1 chk("s4_ready_in_done", in0_ready, 0);
    tick();
    chk("s4_ready_back", in0_ready, 1);
    tick();
    cnt0 = 0;
    for (int i = 0; i < 5; i++) begin drv(0, 0, 0, 0, 0, 0); tick(); end
    chk("s6_one_resp", cnt0, 1);

    // drain with nothing in flight: drained after two edges
    drv(0, 1, 0, 0, 0, 0); tick(); tick();
    chk("s4_empty_drained", drained, 1);
    drv(0, 0, 0, 0, 0, 0); tick(); tick();

    // reset one edge after an accept: no response ever
    cnt0 = 0; cnt1 = 0;
    drv(0, 0, 1, o5, 0, 0); tick();
    drv(1, 0, 0, 0, 0, 0);  tick();
    drv(0, 0, 0, 0, 0, 0);
    chk("s5_pipe", {pipe_E, pipe_D, pipe_C, pipe_B, pipe_A}, 0);
    chk("s5_inflight", inflight, 0);
    chk("s5_drained", drained, 0);
    for (int i = 0; i < 6; i++) tick();
    chk("s5_no_rsp", cnt0 + cnt1, 0);

    // randomized traffic, ops held while waiting for ready
    for (int i = 0; i < 400; i++) begin
      bit r, dr, v0, v1;
      logic [24:0] n0, n1;
      r  = ($urandom_range(0, 99) == 0);
      dr = ($urandom_range(0, 19) == 0) ? !drain_req : drain_req;
      v0 = ($urandom_range(0, 9) < 6);
      v1 = ($urandom_range(0, 9) < 6);
      n0 = (in0_valid && !exp_r0) ? in0_ops : 25'($urandom);
      n1 = (in1_valid && !exp_r1) ? in1_ops : 25'($urandom);
      if (in0_valid && !exp_r0) v0 = 1;
      if (in1_valid && !exp_r1) v1 = 1;
      drv(r, dr, v0, n0, v1, n1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
